// File: rtl/wfg_stim_sine_core.sv
// Sine sample engine: 16-bit phase accumulator -> iterative CORDIC ->
// gain/offset/saturate -> AXI-Stream master.
module wfg_stim_sine_core #(
  parameter int unsigned CORDIC_ITER     = 16,
  parameter int unsigned AXIS_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_q_i,
  input  logic [15:0]                inc_val_q_i,
  input  logic [15:0]                gain_val_q_i,
  input  logic [17:0]                offset_val_q_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o
);

  typedef enum logic [1:0] {IDLE, CALC, SCALE, VALID} state_t;

  localparam int unsigned CW   = $clog2(CORDIC_ITER + 1);
  localparam int unsigned XW   = 24;  // 18-bit sine range plus 4 fractional guard bits
  localparam int unsigned ZW   = 20;  // angle, full turn = 2^20
  localparam int unsigned FRAC = 4;
  // 65535 / CORDIC gain (1.6467602), scaled by 2^FRAC
  localparam logic signed [XW-1:0] X_INIT    = 24'sd636741;
  localparam logic [CW-1:0]        ITER_LAST = CW'(CORDIC_ITER - 1);

  state_t             state_q, state_d;
  logic [15:0]        phase_q, inc_q, gain_q;
  logic signed [17:0] offset_q, tdata_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;
  logic               neg_q;
  logic [CW-1:0]      iter_q;

  logic               load, handshake;
  logic [15:0]        load_phase, fold_angle;
  logic               fold_neg;
  logic signed [XW-1:0] x_sh, y_sh, y_rnd;
  logic signed [ZW-1:0] atan_i;
  logic signed [17:0] mag, sine_raw, sat;
  logic signed [34:0] prod_full, prod, sum;

  // atan(2^-i) with full turn = 2^20
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       return 20'sd131072;
      1:       return 20'sd77376;
      2:       return 20'sd40883;
      3:       return 20'sd20753;
      4:       return 20'sd10417;
      5:       return 20'sd5213;
      6:       return 20'sd2607;
      7:       return 20'sd1304;
      8:       return 20'sd652;
      9:       return 20'sd326;
      10:      return 20'sd163;
      11:      return 20'sd82;
      12:      return 20'sd41;
      13:      return 20'sd20;
      14:      return 20'sd10;
      15:      return 20'sd5;
      default: return '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en_q_i) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC:  if (iter_q == ITER_LAST) state_d = SCALE;
      SCALE: state_d = VALID;
      VALID: begin
        if (wfg_axis_tready_i) begin
          handshake = 1'b1;
          if (ctrl_en_q_i) begin
            load    = 1'b1;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase to load into the CORDIC and its quadrant fold into [-pi/2, pi/2)
  always_comb begin
    load_phase = (state_q == VALID) ? phase_q + inc_q : phase_q;
    fold_neg   = load_phase[15] ^ load_phase[14];
    // Quadrants 1 and 2 are rotated by pi; the sine sign is restored at scale time
    fold_angle = fold_neg ? (load_phase ^ 16'h8000) : load_phase;
  end

  // One CORDIC micro-rotation operand set
  always_comb begin
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    atan_i = atan_lut(int'(iter_q));
  end

  // Round CORDIC output, apply gain and offset, saturate to 18 bits
  always_comb begin
    y_rnd = (y_q + 24'sd8) >>> FRAC;
    if (y_rnd > 24'sd65535)       mag = 18'sd65535;
    else if (y_rnd < -24'sd65535) mag = -18'sd65535;
    else                          mag = y_rnd[17:0];
    sine_raw  = neg_q ? -mag : mag;
    prod_full = $signed(35'(sine_raw)) * $signed(35'({1'b0, gain_q}));
    prod      = prod_full >>> 14;
    sum       = prod + 35'(offset_q);
    if (sum > 35'sd131071)       sat = 18'sh1FFFF;
    else if (sum < -35'sd131072) sat = 18'sh20000;
    else                         sat = sum[17:0];
  end

  // Datapath: register latching, CORDIC iterations, output sample, phase update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= '0;
      inc_q    <= '0;
      gain_q   <= '0;
      offset_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      neg_q    <= 1'b0;
      iter_q   <= '0;
      tdata_q  <= '0;
    end else begin
      if (load) begin
        inc_q    <= inc_val_q_i;
        gain_q   <= gain_val_q_i;
        offset_q <= offset_val_q_i;
        x_q      <= X_INIT;
        y_q      <= '0;
        z_q      <= {fold_angle, {FRAC{1'b0}}};
        neg_q    <= fold_neg;
        iter_q   <= '0;
      end else if (state_q == CALC) begin
        if (!z_q[ZW-1]) begin
          x_q <= x_q - y_sh;
          y_q <= y_q + x_sh;
          z_q <= z_q - atan_i;
        end else begin
          x_q <= x_q + y_sh;
          y_q <= y_q - x_sh;
          z_q <= z_q + atan_i;
        end
        iter_q <= iter_q + CW'(1);
      end
      if (state_q == SCALE) tdata_q <= sat;
      if (handshake)        phase_q <= ctrl_en_q_i ? load_phase : '0;
    end
  end

  assign wfg_axis_tvalid_o = (state_q == VALID);
  assign wfg_axis_tdata_o  = {{(AXIS_DATA_WIDTH-18){tdata_q[17]}}, tdata_q};

endmodule

// File: tb/tb_wfg_stim_sine_core.sv
// Scoreboard bench for wfg_stim_sine_core: directed configurations with
// hand-computed sine samples, latency, backpressure, disable and reset cases.
module tb_wfg_stim_sine_core;

  localparam int unsigned ITER = 16;
  localparam int unsigned DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   inc = '0;
  logic [15:0]   gain = '0;
  logic [17:0]   offset = '0;
  logic          tready = 1'b1;
  logic          tvalid;
  logic [DW-1:0] tdata;

  always #5 clk = ~clk;

  wfg_stim_sine_core #(
    .CORDIC_ITER    (ITER),
    .AXIS_DATA_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_en_q_i      (en),
    .inc_val_q_i      (inc),
    .gain_val_q_i     (gain),
    .offset_val_q_i   (offset),
    .wfg_axis_tready_i(tready),
    .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tdata_o (tdata)
  );

  typedef struct {
    string name;
    int    val;
    int    tol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic push_exp(input string name, input int val, input int tol);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.tol  = tol;
    sb.push_back(e);
  endtask

  // Monitor: every accepted beat is compared against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tvalid && tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0d, expected no sample", $signed(tdata));
        end else begin
          e = sb.pop_front();
          check(e.name, $signed(tdata), e.val, e.tol);
        end
      end
    end
  end

  // Count edges until tvalid is seen 1 ns after an edge; bounded
  task automatic wait_valid(input string name, output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!tvalid && k < 100);
    if (!tvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: tvalid low after %0d cycles, expected high", name, k);
    end
  endtask

  // Enable, collect n samples with tready=1, drop enable before the last handshake
  task automatic stream(input string name, input int n);
    int k;
    en = 1'b1;
    for (int s = 1; s <= n; s++) begin
      wait_valid(name, k);
      // The edge that sees en (or the handshake) is counted as 1: sample appears after ITER+1 more edges
      check({name, "_latency"}, k, int'(ITER) + 2, 0);
      if (s == n) en = 1'b0;
    end
    @(posedge clk);
    #1;
    check({name, "_idle"}, int'(tvalid), 0, 0);
  endtask

  initial begin : stim
    int k;

    // Reset with enable and ready high: nothing may come out
    rst_n = 1'b0; en = 1'b1; tready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_tvalid", int'(tvalid), 0, 0);
      check("reset_tdata", $signed(tdata), 0, 0);
    end
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-point cycle with unity gain, wrapping 0xC000 -> 0x0000
    gain = 16'h4000; offset = '0; inc = 16'h4000;
    push_exp("cyc_p0000", 0, 8);
    push_exp("cyc_p4000", 65535, 8);
    push_exp("cyc_p8000", 0, 8);
    push_exp("cyc_pC000", -65535, 8);
    push_exp("cyc_wrap_p0000", 0, 8);
    push_exp("cyc_wrap_p4000", 65535, 8);
    stream("cyc", 6);

    // Gain 2.0, no saturation
    gain = 16'h8000; offset = '0; inc = 16'h4000;
    push_exp("g2_p0000", 0, 16);
    push_exp("g2_p4000", 131070, 16);
    stream("g2", 2);

    // Positive clamp
    gain = 16'h4000; offset = 18'h1FFFF; inc = 16'h4000;
    push_exp("pos_p0000", 131071, 8);
    push_exp("pos_clamp_p4000", 131071, 0);
    stream("pos", 2);

    // Negative clamp
    gain = 16'h4000; offset = 18'h20000; inc = 16'h4000;
    push_exp("neg_p0000", -131072, 8);
    push_exp("neg_p4000", -65537, 8);
    push_exp("neg_p8000", -131072, 8);
    push_exp("neg_clamp_pC000", -131072, 0);
    stream("neg", 4);

    // Backpressure: stalled beat holds, phase advances only once
    gain = 16'h4000; offset = '0; inc = 16'h1000;
    tready = 1'b0;
    push_exp("bp_held_p0000", 0, 8);
    push_exp("bp_next_p1000", 25079, 8);
    en = 1'b1;
    wait_valid("bp", k);
    check("bp_latency", k, int'(ITER) + 2, 0);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_tvalid_held", int'(tvalid), 1, 0);
      check("bp_tdata_held", $signed(tdata), 0, 8);
    end
    tready = 1'b1;
    wait_valid("bp_next", k);
    check("bp_next_latency", k, int'(ITER) + 2, 0);
    en = 1'b0;
    @(posedge clk);
    #1;

    // Disable five cycles into CALC: in-flight sample delivered, then phase cleared
    gain = 16'h4000; offset = '0; inc = 16'h2000;
    push_exp("dis_first_p0000", 0, 8);
    push_exp("dis_inflight_p2000", 46341, 8);
    en = 1'b1;
    wait_valid("dis_first", k);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid("dis_inflight", k);
    @(posedge clk);
    repeat (20) begin
      @(posedge clk);
      #1;
      check("dis_idle_tvalid", int'(tvalid), 0, 0);
    end
    push_exp("dis_reenable_p0000", 0, 8);
    stream("dis_re", 1);

    // Reset pulse mid-CALC: in-flight sample dropped, phase restarts at 0
    gain = 16'h4000; offset = '0; inc = 16'h4000;
    push_exp("rst_first_p0000", 0, 8);
    push_exp("rst_restart_p0000", 0, 8);
    en = 1'b1;
    wait_valid("rst_first", k);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_tvalid", int'(tvalid), 0, 0);
    check("rst_mid_tdata", $signed(tdata), 0, 0);
    rst_n = 1'b1;
    wait_valid("rst_restart", k);
    check("rst_restart_latency", k, int'(ITER) + 2, 0);
    en = 1'b0;
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
